// File: rtl/fifo_tx_defs_pkg.sv
// Shared definitions for the SpaceWire transmit FIFO: default geometry,
// N-char control codes and the per-cycle event bundle used by the FIFO core.
package fifo_tx_defs;

  localparam int DEF_DWIDTH   = 9;
  localparam int DEF_AWIDTH   = 6;
  localparam int DEF_CTRL_BIT = 8;

  localparam logic [8:0] EOP = 9'h100;
  localparam logic [8:0] EEP = 9'h101;

  typedef struct packed {
    logic wr_acc;  // write accepted into memory
    logic load;    // memory head moved into the output register
    logic hs;      // output register consumed by the encoder
  } fifo_evt_t;

endpackage

// File: rtl/fifo_tx_ram.sv
// Simple dual-port storage: synchronous write, registered read, no reset,
// so it maps directly onto block RAM.
module fifo_tx_ram #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_tx_param.sv
// SpaceWire TX FIFO: single-cycle writes, valid/ready output register,
// almost-full, flush, sticky overflow and a count of stored end-of-packet chars.
module fifo_tx_param
  import fifo_tx_defs::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int AF_LEVEL = 56,
  parameter int CTRL_BIT = DEF_CTRL_BIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              write_tx,
  output logic              f_full,
  output logic              f_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   counter,
  output logic [AWIDTH:0]   packets,
  output logic              overflow
);

  localparam int            DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   mem_count_q, mem_count_d;
  logic [AWIDTH:0]   pkt_q, pkt_d;
  logic              write_tx_q, write_tx_d;
  logic              ovf_q, ovf_d;
  logic              dout_vld_q, dout_vld_d;
  logic [DWIDTH-1:0] ram_rdata;
  logic              ram_we, ram_re;
  logic              pkt_inc, pkt_dec;
  fifo_evt_t         evt;

  assign f_full      = (mem_count_q == DEPTH_C);
  assign almost_full = (mem_count_q >= AF_C);
  assign counter     = mem_count_q + (AWIDTH+1)'(write_tx_q);
  assign f_empty     = (counter == '0);
  assign write_tx    = write_tx_q;
  assign packets     = pkt_q;
  assign overflow    = ovf_q;
  // The RAM read register cannot be reset, so data_out reads zero until the first load.
  assign data_out    = dout_vld_q ? ram_rdata : '0;

  always_comb begin
    evt.wr_acc  = wr_en && !f_full;
    evt.load    = (!write_tx_q || rd_en) && (mem_count_q != '0);
    evt.hs      = write_tx_q && rd_en;
    pkt_inc     = evt.wr_acc && data_in[CTRL_BIT];
    pkt_dec     = evt.hs && data_out[CTRL_BIT];
    ram_we      = evt.wr_acc && reset && !flush;
    ram_re      = evt.load && reset && !flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    pkt_d       = pkt_q;
    write_tx_d  = write_tx_q;
    ovf_d       = ovf_q;
    dout_vld_d  = dout_vld_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      pkt_d       = '0;
      write_tx_d  = 1'b0;
      ovf_d       = 1'b0;
      dout_vld_d  = 1'b0;
    end else begin
      if (evt.wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      if (wr_en && f_full) ovf_d = 1'b1;
      if (evt.load) begin
        rd_ptr_d   = rd_ptr_q + AWIDTH'(1);
        write_tx_d = 1'b1;
        dout_vld_d = 1'b1;
      end else if (evt.hs) begin
        write_tx_d = 1'b0;
      end
      unique case ({evt.wr_acc, evt.load})
        2'b10:   mem_count_d = mem_count_q + ONE_C;
        2'b01:   mem_count_d = mem_count_q - ONE_C;
        default: mem_count_d = mem_count_q;
      endcase
      unique case ({pkt_inc, pkt_dec})
        2'b10:   pkt_d = pkt_q + ONE_C;
        2'b01:   pkt_d = pkt_q - ONE_C;
        default: pkt_d = pkt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      pkt_q       <= '0;
      write_tx_q  <= 1'b0;
      ovf_q       <= 1'b0;
      dout_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      pkt_q       <= pkt_d;
      write_tx_q  <= write_tx_d;
      ovf_q       <= ovf_d;
      dout_vld_q  <= dout_vld_d;
    end
  end

  fifo_tx_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk  (clock),
    .we   (ram_we),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .re   (ram_re),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_fifo_tx_param.sv
// Scenario bench for fifo_tx_param: a queue model of memory plus output register,
// and a scoreboard of words expected on each completed handshake.
module tb_fifo_tx_param;
  import fifo_tx_defs::*;

  localparam int DEPTH = 64;
  localparam int AF    = 56;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [8:0] data_in = '0;
  logic [8:0] data_out;
  logic       write_tx, f_full, f_empty, almost_full, overflow;
  logic [6:0] counter, packets;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] mq[$];
  logic [8:0] sb[$];
  bit         m_wt = 0;
  logic [8:0] m_out = '0;
  bit         m_ovf = 0;

  fifo_tx_param #(.DWIDTH(9), .AWIDTH(6), .AF_LEVEL(AF), .CTRL_BIT(8)) dut (
    .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .write_tx(write_tx), .f_full(f_full),
    .f_empty(f_empty), .almost_full(almost_full), .counter(counter),
    .packets(packets), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic int m_cnt();
    return mq.size() + int'(m_wt);
  endfunction

  function automatic int m_pkt();
    int p = 0;
    foreach (mq[i]) if (mq[i][8]) p++;
    if (m_wt && m_out[8]) p++;
    return p;
  endfunction

  // Advance one clock with the inputs currently driven; returns handshake info.
  task automatic step(output bit hs, output logic [8:0] got, output logic [8:0] exp);
    bit full, load, acc;
    hs  = m_wt && rd_en && reset && !flush;
    got = data_out;
    exp = 'x;
    if (hs && sb.size() != 0) exp = sb.pop_front();
    if (!reset || flush) begin
      mq.delete(); sb.delete();
      m_wt = 0; m_out = '0; m_ovf = 0;
    end else begin
      full = (mq.size() == DEPTH);
      acc  = wr_en && !full;
      if (wr_en && full) m_ovf = 1;
      load = (!m_wt || rd_en) && mq.size() != 0;
      if (load) begin
        m_out = mq.pop_front();
        m_wt  = 1;
      end else if (m_wt && rd_en) begin
        m_wt = 0;
      end
      if (acc) begin
        mq.push_back(data_in);
        sb.push_back(data_in);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bit hs; logic [8:0] got, exp;
    reset = 0; wr_en = 1; data_in = 9'h055; rd_en = 1;
    step(hs, got, exp);
    step(hs, got, exp);
    reset = 1; wr_en = 0; rd_en = 0;
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL reset_counter got %0d want 0", counter); end
    n_vec++; if (write_tx !== 1'b0) begin n_err++; $display("FAIL reset_write_tx got %b want 0", write_tx); end
    n_vec++; if (data_out !== 9'h000) begin n_err++; $display("FAIL reset_data_out got %h want 000", data_out); end
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL reset_f_empty got %b want 1", f_empty); end
    n_vec++; if (f_full !== 1'b0) begin n_err++; $display("FAIL reset_f_full got %b want 0", f_full); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_vec++; if (packets !== 7'd0) begin n_err++; $display("FAIL reset_packets got %0d want 0", packets); end
  endtask

  task automatic test_basic();
    bit hs; logic [8:0] got, exp;
    logic [8:0] w [3] = '{9'h011, 9'h022, EOP};
    int nd = 0;
    bit saw_pkt = 0;
    rd_en = 1;
    for (int t = 0; t < 8; t++) begin
      wr_en   = (t < 3);
      data_in = (t < 3) ? w[t] : 9'h1FF;
      step(hs, got, exp);
      wr_en = 0;
      if (t == 0) begin
        n_vec++; if (write_tx !== 1'b0) begin n_err++; $display("FAIL basic_latency_k got %b want 0", write_tx); end
      end
      if (t == 1) begin
        n_vec++; if (write_tx !== 1'b1) begin n_err++; $display("FAIL basic_latency_k1 got %b want 1", write_tx); end
      end
      if (hs) begin
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL basic_data got %h want %h", got, exp); end
        nd++;
      end
      n_vec++; if (packets !== 7'(m_pkt())) begin n_err++; $display("FAIL basic_packets got %0d want %0d", packets, m_pkt()); end
      if (packets == 7'd1) saw_pkt = 1;
    end
    n_vec++; if (nd != 3) begin n_err++; $display("FAIL basic_delivered got %0d want 3", nd); end
    n_vec++; if (saw_pkt != 1'b1) begin n_err++; $display("FAIL basic_packets_peak got %b want 1", saw_pkt); end
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL basic_counter got %0d want 0", counter); end
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL basic_f_empty got %b want 1", f_empty); end
    rd_en = 0;
  endtask

  task automatic test_fill();
    bit hs; logic [8:0] got, exp;
    rd_en = 0;
    for (int i = 0; i < 66; i++) begin
      wr_en   = 1;
      data_in = (i % 8 == 7) ? {1'b1, 8'(i)} : 9'(i);
      step(hs, got, exp);
      n_vec++; if (counter !== 7'(m_cnt())) begin n_err++; $display("FAIL fill_counter i=%0d got %0d want %0d", i, counter, m_cnt()); end
      n_vec++; if (almost_full !== (mq.size() >= AF)) begin n_err++; $display("FAIL fill_almost_full i=%0d got %b want %b", i, almost_full, mq.size() >= AF); end
      n_vec++; if (f_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL fill_f_full i=%0d got %b want %b", i, f_full, mq.size() == DEPTH); end
      n_vec++; if (packets !== 7'(m_pkt())) begin n_err++; $display("FAIL fill_packets i=%0d got %0d want %0d", i, packets, m_pkt()); end
      if (i == 55) begin
        n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL fill_af_below got %b want 0", almost_full); end
      end
      if (i == 56) begin
        n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL fill_af_at_level got %b want 1", almost_full); end
      end
      if (i == 63) begin
        n_vec++; if (counter !== 7'd64) begin n_err++; $display("FAIL fill_64_counter got %0d want 64", counter); end
        n_vec++; if (f_full !== 1'b0) begin n_err++; $display("FAIL fill_64_f_full got %b want 0", f_full); end
      end
      if (i == 64) begin
        n_vec++; if (f_full !== 1'b1) begin n_err++; $display("FAIL fill_65_f_full got %b want 1", f_full); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_65_overflow got %b want 0", overflow); end
      end
      if (i == 65) begin
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow got %b want 1", overflow); end
        n_vec++; if (counter !== 7'd65) begin n_err++; $display("FAIL fill_dropped counter got %0d want 65", counter); end
      end
    end
    wr_en = 0;
  endtask

  task automatic test_flush();
    bit hs; logic [8:0] got, exp;
    rd_en = 1;
    for (int c = 0; c < 100 && m_cnt() > 20; c++) begin
      step(hs, got, exp);
      if (hs) begin
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL flush_drain_data got %h want %h", got, exp); end
      end
    end
    rd_en = 0;
    n_vec++; if (counter !== 7'd20) begin n_err++; $display("FAIL flush_pre_counter got %0d want 20", counter); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL flush_pre_overflow got %b want 1", overflow); end
    flush = 1; wr_en = 1; rd_en = 1; data_in = EOP;
    step(hs, got, exp);
    flush = 0; wr_en = 0; rd_en = 0;
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL flush_counter got %0d want 0", counter); end
    n_vec++; if (packets !== 7'd0) begin n_err++; $display("FAIL flush_packets got %0d want 0", packets); end
    n_vec++; if (write_tx !== 1'b0) begin n_err++; $display("FAIL flush_write_tx got %b want 0", write_tx); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL flush_overflow got %b want 0", overflow); end
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL flush_f_empty got %b want 1", f_empty); end
    n_vec++; if (data_out !== 9'h000) begin n_err++; $display("FAIL flush_data_out got %h want 000", data_out); end
    step(hs, got, exp);
    step(hs, got, exp);
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL flush_write_absent counter got %0d want 0", counter); end
    n_vec++; if (write_tx !== 1'b0) begin n_err++; $display("FAIL flush_write_absent write_tx got %b want 0", write_tx); end
  endtask

  task automatic test_wrap();
    bit hs; logic [8:0] got, exp;
    int nd = 0;
    rd_en = 0;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1; data_in = (i % 5 == 4) ? {1'b1, 8'(i)} : 9'(i + 100);
      step(hs, got, exp);
    end
    n_vec++; if (counter !== 7'd64) begin n_err++; $display("FAIL wrap_pre_counter got %0d want 64", counter); end
    rd_en = 1;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; data_in = 9'(200 + i);
      step(hs, got, exp);
      if (hs) begin
        nd++;
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL wrap_data got %h want %h", got, exp); end
      end
      n_vec++; if (counter !== 7'd64) begin n_err++; $display("FAIL wrap_counter got %0d want 64", counter); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow got %b want 0", overflow); end
    end
    wr_en = 0;
    for (int c = 0; c < 100 && m_cnt() != 0; c++) begin
      step(hs, got, exp);
      if (hs) begin
        nd++;
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL wrap_drain_data got %h want %h", got, exp); end
      end
    end
    rd_en = 0;
    n_vec++; if (nd != 74) begin n_err++; $display("FAIL wrap_delivered got %0d want 74", nd); end
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL wrap_f_empty got %b want 1", f_empty); end
    n_vec++; if (packets !== 7'd0) begin n_err++; $display("FAIL wrap_packets got %0d want 0", packets); end
  endtask

  task automatic test_stall();
    bit hs; logic [8:0] got, exp;
    logic [8:0] w [3] = '{9'h0AA, 9'h0BB, EEP};
    rd_en = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; data_in = w[i];
      step(hs, got, exp);
    end
    wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      step(hs, got, exp);
      n_vec++; if (data_out !== 9'h0AA) begin n_err++; $display("FAIL stall_data_out cyc=%0d got %h want 0aa", i, data_out); end
      n_vec++; if (write_tx !== 1'b1) begin n_err++; $display("FAIL stall_write_tx cyc=%0d got %b want 1", i, write_tx); end
    end
    rd_en = 1;
    step(hs, got, exp);
    rd_en = 0;
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL stall_release got %h want %h", got, exp); end
    n_vec++; if (data_out !== 9'h0BB) begin n_err++; $display("FAIL stall_next_word got %h want 0bb", data_out); end
    n_vec++; if (packets !== 7'd1) begin n_err++; $display("FAIL stall_packets got %0d want 1", packets); end
    rd_en = 1;
    for (int c = 0; c < 10 && m_cnt() != 0; c++) begin
      step(hs, got, exp);
      if (hs) begin
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL stall_drain_data got %h want %h", got, exp); end
      end
    end
    rd_en = 0;
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL stall_counter got %0d want 0", counter); end
  endtask

  task automatic test_reset_mid();
    bit hs; logic [8:0] got, exp;
    int nd = 0;
    rd_en = 0;
    for (int i = 0; i < 65; i++) begin
      wr_en = 1; data_in = (i == 10) ? EOP : 9'(i + 3);
      step(hs, got, exp);
    end
    n_vec++; if (f_full !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_f_full got %b want 1", f_full); end
    n_vec++; if (write_tx !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_write_tx got %b want 1", write_tx); end
    reset = 0; wr_en = 1; rd_en = 1; data_in = EOP;
    step(hs, got, exp);
    reset = 1; wr_en = 0; rd_en = 0;
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL rstmid_counter got %0d want 0", counter); end
    n_vec++; if (write_tx !== 1'b0) begin n_err++; $display("FAIL rstmid_write_tx got %b want 0", write_tx); end
    n_vec++; if (data_out !== 9'h000) begin n_err++; $display("FAIL rstmid_data_out got %h want 000", data_out); end
    n_vec++; if (f_full !== 1'b0) begin n_err++; $display("FAIL rstmid_f_full got %b want 0", f_full); end
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL rstmid_f_empty got %b want 1", f_empty); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rstmid_almost_full got %b want 0", almost_full); end
    n_vec++; if (packets !== 7'd0) begin n_err++; $display("FAIL rstmid_packets got %0d want 0", packets); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    rd_en = 1;
    for (int t = 0; t < 8; t++) begin
      wr_en = (t < 2); data_in = (t == 0) ? 9'h033 : EOP;
      step(hs, got, exp);
      wr_en = 0;
      if (hs) begin
        nd++;
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL rstmid_resume_data got %h want %h", got, exp); end
      end
    end
    rd_en = 0;
    n_vec++; if (nd != 2) begin n_err++; $display("FAIL rstmid_resume_count got %0d want 2", nd); end
    n_vec++; if (counter !== 7'd0) begin n_err++; $display("FAIL rstmid_resume_counter got %0d want 0", counter); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_flush();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached with %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end

endmodule
